vga_sync_gen: RTL and testbench

VGA raster timing generator for the game platform's video path. Sits directly downstream of the clock divider: its clock is the divider's output (25 MHz pixel clock from the 50 MHz board clock). It produces horizontal/vertical sync, a visible-area flag, pixel coordinates and frame/line strobes for the pixel renderer.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_axis_counter.sv | 66 ++++++
 rtl/vga_sync_gen.sv | 137 +++++++++++++
 tb/tb_vga_sync_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60 timing constants, coordinate width and
//               raster phase encoding for the VGA sync generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int c_h_visible = 640;
    localparam int c_h_front   = 16;
    localparam int c_h_sync    = 96;
    localparam int c_h_back    = 48;

    localparam int c_v_visible = 480;
    localparam int c_v_front   = 10;
    localparam int c_v_sync    = 2;
    localparam int c_v_back    = 33;

    localparam int c_h_total = c_h_visible + c_h_front + c_h_sync + c_h_back;
    localparam int c_v_total = c_v_visible + c_v_front + c_v_sync + c_v_back;

    localparam int c_coord_w = 10;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module      : vga_axis_counter
// Description : Wrap-around raster axis counter with enable, terminal-count
//               flag and ACTIVE/FRONT/SYNC/BACK phase decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = c_h_visible,
    parameter int FRONT   = c_h_front,
    parameter int SYNC    = c_h_sync,
    parameter int BACK    = c_h_back,
    parameter int WIDTH   = c_coord_w
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [1:0]       phase
);

    localparam int c_total = VISIBLE + FRONT + SYNC + BACK;

    localparam logic [WIDTH-1:0] c_last       = WIDTH'(c_total - 1);
    localparam logic [WIDTH-1:0] c_sync_start = WIDTH'(VISIBLE + FRONT);
    localparam logic [WIDTH-1:0] c_back_start = WIDTH'(VISIBLE + FRONT + SYNC);
    localparam logic [WIDTH-1:0] c_vis_end    = WIDTH'(VISIBLE);

    logic [WIDTH-1:0] r_count;
    logic             w_tc;
    phase_t           w_phase;

    assign w_tc = (r_count == c_last);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_tc ? '0 : r_count + 1'b1;
        end
    end

    always_comb begin
        w_phase = PH_ACTIVE;
        if (r_count < c_vis_end) begin
            w_phase = PH_ACTIVE;
        end else if (r_count < c_sync_start) begin
            w_phase = PH_FRONT;
        end else if (r_count < c_back_start) begin
            w_phase = PH_SYNC;
        end else begin
            w_phase = PH_BACK;
        end
    end

    assign count = r_count;
    assign tc    = w_tc;
    assign phase = w_phase;

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing generator producing registered syncs,
//               visible flag, pixel coordinates and line/frame strobes.
//               Optional frame counter output enabled by VGA_SYNC_FRAME_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = c_h_visible,
    parameter int H_FRONT   = c_h_front,
    parameter int H_SYNC    = c_h_sync,
    parameter int H_BACK    = c_h_back,
    parameter int V_VISIBLE = c_v_visible,
    parameter int V_FRONT   = c_v_front,
    parameter int V_SYNC    = c_v_sync,
    parameter int V_BACK    = c_v_back
) (
    input  logic                 clk_in,
    input  logic                 rst,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_on,
    output logic [c_coord_w-1:0] pixel_x,
    output logic [c_coord_w-1:0] pixel_y,
    output logic                 line_start,
    output logic                 frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0]           frame_cnt
`endif
);

    logic [c_coord_w-1:0] w_h_cnt;
    logic [c_coord_w-1:0] w_v_cnt;
    logic                 w_h_tc;
    logic                 w_v_tc_unused;
    logic [1:0]           w_h_phase;
    logic [1:0]           w_v_phase;
    logic                 w_frame_origin;

    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_video_on;
    logic [c_coord_w-1:0] r_pixel_x;
    logic [c_coord_w-1:0] r_pixel_y;
    logic                 r_line_start;
    logic                 r_frame_start;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .WIDTH   (c_coord_w)
    ) u_h_axis (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (1'b1),
        .count   (w_h_cnt),
        .tc      (w_h_tc),
        .phase   (w_h_phase)
    );

    // Vertical axis advances once per completed line.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .WIDTH   (c_coord_w)
    ) u_v_axis (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (w_h_tc),
        .count   (w_v_cnt),
        .tc      (w_v_tc_unused),
        .phase   (w_v_phase)
    );

    assign w_frame_origin = (w_h_cnt == '0) && (w_v_cnt == '0);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= (w_h_phase != PH_SYNC);
            r_vsync       <= (w_v_phase != PH_SYNC);
            r_video_on    <= (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);
            r_pixel_x     <= w_h_cnt;
            r_pixel_y     <= w_v_cnt;
            r_line_start  <= (w_h_cnt == '0);
            r_frame_start <= w_frame_origin;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;
    logic       r_first_frame;

    // The first frame after reset is frame 0; later frame starts advance.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_frame_cnt   <= 8'd0;
            r_first_frame <= 1'b1;
        end else if (w_frame_origin) begin
            if (r_first_frame) begin
                r_first_frame <= 1'b0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Directed self-checking bench: a default-timing instance for
//               line timing and a reduced-timing instance for frame behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic       d_hsync, d_vsync, d_von, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hsync, s_vsync, s_von, s_ls, s_fs;
    logic [9:0] s_x, s_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] d_fcnt, s_fcnt;
`endif

    int total = 0;
    int bad   = 0;

    vga_sync_gen u_def (
        .clk_in      (clk),
        .rst         (rst),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .video_on    (d_von),
        .pixel_x     (d_x),
        .pixel_y     (d_y),
        .line_start  (d_ls),
        .frame_start (d_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt   (d_fcnt)
`endif
    );

    // Reduced raster: 16 cycles per line, 10 lines per frame, 160 cycles/frame.
    vga_sync_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (4), .V_FRONT (2), .V_SYNC (2), .V_BACK (2)
    ) u_sml (
        .clk_in      (clk),
        .rst         (rst),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .video_on    (s_von),
        .pixel_x     (s_x),
        .pixel_y     (s_y),
        .line_start  (s_ls),
        .frame_start (s_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt   (s_fcnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low, hs_first, hs_last, von_low, ls_cnt, y_bad;
        int vs_low, vs_first_x, vs_first_y, fs_cnt, fs_second, von_cnt, end_x, end_y;
        int found, y_before;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_hsync",  d_hsync, 1);
        chk("rst_vsync",  d_vsync, 1);
        chk("rst_von",    d_von,   0);
        chk("rst_x",      d_x,     0);
        chk("rst_y",      d_y,     0);
        chk("rst_ls",     d_ls,    0);
        chk("rst_fs",     d_fs,    0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("rst_fcnt",   d_fcnt,  0);
`endif

        // ---------------- release ----------------
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("first_fs",   d_fs,    1);
        chk("first_ls",   d_ls,    1);
        chk("first_x",    d_x,     0);
        chk("first_y",    d_y,     0);
        chk("first_von",  d_von,   1);
        chk("first_hs",   d_hsync, 1);
        chk("sml_first_fs", s_fs,  1);
        tick();
        chk("second_x",   d_x,     1);
        chk("second_fs",  d_fs,    0);
        chk("second_ls",  d_ls,    0);

        // ---------------- one default line (x = 1..799) ----------------
        hs_low = 0; hs_first = 1023; hs_last = -1; von_low = 0; ls_cnt = 0; y_bad = 0;
        for (int i = 0; i < 799; i++) begin
            if (!d_hsync) begin
                hs_low++;
                if (hs_first == 1023) hs_first = int'(d_x);
                hs_last = int'(d_x);
            end
            if (!d_von) von_low++;
            if (d_ls) ls_cnt++;
            if (d_y != 10'd0) y_bad++;
            tick();
        end
        chk("line_hs_low_cycles", hs_low,   96);
        chk("line_hs_first_x",    hs_first, 656);
        chk("line_hs_last_x",     hs_last,  751);
        chk("line_von_low",       von_low,  160);
        chk("line_ls_midline",    ls_cnt,   0);
        chk("line_y_stable",      y_bad,    0);
        chk("line1_x",            d_x,      0);
        chk("line1_y",            d_y,      1);
        chk("line1_ls",           d_ls,     1);
        chk("line1_fs",           d_fs,     0);
        chk("line1_vs",           d_vsync,  1);
        chk("sml_c800_fs",        s_fs,     1);
        chk("sml_c800_xy",        {s_y, s_x}, 20'd0);

        // ---------------- two reduced frames (cycles 800..1119) ----------------
        vs_low = 0; vs_first_x = -1; vs_first_y = -1; fs_cnt = 0; fs_second = -1;
        von_cnt = 0; hs_low = 0; end_x = -1; end_y = -1;
        for (int i = 0; i < 320; i++) begin
            if (!s_vsync) begin
                if (vs_low == 0) begin
                    vs_first_x = int'(s_x);
                    vs_first_y = int'(s_y);
                end
                vs_low++;
            end
            if (s_fs) begin
                fs_cnt++;
                if (i != 0 && fs_second < 0) fs_second = i;
            end
            if (s_von) von_cnt++;
            if (!s_hsync) hs_low++;
            if (i == 319) begin
                end_x = int'(s_x);
                end_y = int'(s_y);
            end
            tick();
        end
        chk("frm_vs_low_cycles", vs_low,     64);
        chk("frm_vs_first_x",    vs_first_x, 0);
        chk("frm_vs_first_y",    vs_first_y, 6);
        chk("frm_fs_count",      fs_cnt,     2);
        chk("frm_fs_period",     fs_second,  160);
        chk("frm_von_cycles",    von_cnt,    64);
        chk("frm_hs_low_cycles", hs_low,     60);
        chk("frm_last_x",        end_x,      15);
        chk("frm_last_y",        end_y,      9);
        chk("frm_wrap_fs",       s_fs,       1);
        chk("frm_wrap_xy",       {s_y, s_x}, 20'd0);
        chk("def_c1120_x",       d_x,        320);
        chk("def_c1120_y",       d_y,        1);

`ifdef VGA_SYNC_FRAME_CNT_EN
        // ---------------- frame counter over frames 7..256 ----------------
        begin
            int cnt_err, v255, v256;
            cnt_err = 0; v255 = -1; v256 = -1;
            chk("fcnt_frame7", s_fcnt, 7);
            chk("fcnt_def_frame0", d_fcnt, 0);
            for (int k = 8; k <= 256; k++) begin
                repeat (159) tick();
                if (int'(s_fcnt) != (k - 1) % 256) cnt_err++;
                if (k == 256) v255 = int'(s_fcnt);
                tick();
                if (int'(s_fcnt) != k % 256 || !s_fs) cnt_err++;
                if (k == 256) v256 = int'(s_fcnt);
            end
            chk("fcnt_seq_errors", cnt_err, 0);
            chk("fcnt_frame255",   v255,    255);
            chk("fcnt_frame256",   v256,    0);
        end
`endif

        // ---------------- asynchronous mid-line reset ----------------
        found = 0;
        for (int i = 0; i < 800 && found == 0; i++) begin
            if (d_x == 10'd300) found = 1;
            else tick();
        end
        chk("wait_x300", found, 1);
        y_before = int'(d_y);
        chk("pre_rst_y_nonzero", (y_before != 0), 1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_x",     d_x,     0);
        chk("async_y",     d_y,     0);
        chk("async_hsync", d_hsync, 1);
        chk("async_vsync", d_vsync, 1);
        chk("async_von",   d_von,   0);
        chk("async_ls",    d_ls,    0);
        chk("async_fs",    d_fs,    0);
        chk("async_sml_x", s_x,     0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("async_fcnt",  s_fcnt,  0);
`endif
        repeat (2) tick();
        chk("held_rst_x",  d_x,     0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("restart_fs",  d_fs,    1);
        chk("restart_ls",  d_ls,    1);
        chk("restart_xy",  {d_y, d_x}, 20'd0);
        chk("restart_von", d_von,   1);
        tick();
        chk("restart_x1",  d_x,     1);
        chk("restart_fs0", d_fs,    0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("restart_fcnt", s_fcnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
